// File: rtl/shift_reg_univ.sv
// Universal shift register: load, logical/arithmetic shift and rotate, one
// bit position per clock, with a START/BUSY/DONE command handshake.
module shift_reg_univ #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_mode,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_ip,
    output logic [WIDTH-1:0] o_op,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] MODE_LOAD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ASR  = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_op, w_op_nxt;
    logic             r_sout, w_sout_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic [AMT_W-1:0] r_rem, w_rem_nxt;

    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_op;
    logic             w_step_sout;

    // One single-bit step of the selected operation; reserved modes hold
    always_comb begin
        w_step_op   = r_op;
        w_step_sout = r_sout;
        case (w_step_mode)
            MODE_SHL: begin
                w_step_op   = {r_op[WIDTH-2:0], i_sin};
                w_step_sout = r_op[WIDTH-1];
            end
            MODE_SHR: begin
                w_step_op   = {i_sin, r_op[WIDTH-1:1]};
                w_step_sout = r_op[0];
            end
            MODE_ROR: begin
                w_step_op   = {r_op[0], r_op[WIDTH-1:1]};
                w_step_sout = r_op[0];
            end
            MODE_ROL: begin
                w_step_op   = {r_op[WIDTH-2:0], r_op[WIDTH-1]};
                w_step_sout = r_op[WIDTH-1];
            end
            MODE_ASR: begin
                w_step_op   = {r_op[WIDTH-1], r_op[WIDTH-1:1]};
                w_step_sout = r_op[0];
            end
            default: begin
                w_step_op   = r_op;
                w_step_sout = r_op[0] & 1'b0 | r_sout;
            end
        endcase
    end

    // Next-state and next-output logic for the command sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_sout_nxt  = r_sout;
        w_done_nxt  = 1'b0;
        w_mode_nxt  = r_mode;
        w_rem_nxt   = r_rem;
        w_step_mode = (r_state == ST_SHIFT) ? r_mode : i_mode;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_mode_nxt = i_mode;
                    if (i_mode == MODE_LOAD) begin
                        w_op_nxt   = i_ip;
                        w_done_nxt = 1'b1;
                    end else if (i_mode > MODE_ASR || i_amt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_op_nxt   = w_step_op;
                        w_sout_nxt = w_step_sout;
                        if (i_amt == AMT_W'(1)) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_rem_nxt   = i_amt - AMT_W'(1);
                            w_state_nxt = ST_SHIFT;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                w_op_nxt   = w_step_op;
                w_sout_nxt = w_step_sout;
                w_rem_nxt  = r_rem - AMT_W'(1);
                if (r_rem == AMT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_SHIFT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_mode  <= w_mode_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign o_op   = r_op;
    assign o_sout = r_sout;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8, AMT_W=4).
module tb_shift_reg_univ;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [2:0] i_mode = 3'b000;
    logic [3:0] i_amt = 4'd0;
    logic       i_sin = 1'b0;
    logic [7:0] i_ip = 8'h00;
    logic [7:0] o_op;
    logic       o_sout;
    logic       o_busy;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_amt   (i_amt),
        .i_sin   (i_sin),
        .i_ip    (i_ip),
        .o_op    (o_op),
        .o_sout  (o_sout),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    // Advance to the next sampling point (falling edge)
    task automatic tick();
        @(negedge i_clk);
    endtask

    // Present a command for one rising edge (t0); returns at the falling edge of cycle t0+1
    task automatic issue(input logic [2:0] m, input logic [3:0] a,
                         input logic [7:0] d, input logic s);
        i_start = 1'b1;
        i_mode  = m;
        i_amt   = a;
        i_ip    = d;
        i_sin   = s;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== 11'b0) begin
            bad++;
            $display("FAIL reset got=%h/%b/%b/%b exp=00/0/0/0", o_op, o_sout, o_busy, o_done);
        end
    endtask

    task automatic test_load();
        issue(3'b000, 4'd0, 8'hA5, 1'b0);
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'hA5, 3'b001}) begin
            bad++;
            $display("FAIL load got=%h/%b/%b/%b exp=a5/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
        total++;
        if ({o_op, o_busy, o_done} !== {8'hA5, 2'b00}) begin
            bad++;
            $display("FAIL load_done_pulse got=%h/%b/%b exp=a5/0/0", o_op, o_busy, o_done);
        end
    endtask

    task automatic test_shl();
        logic [7:0] exp_op [3];
        logic [2:0] exp_flags [3];
        exp_op[0] = 8'h4B; exp_flags[0] = 3'b110;
        exp_op[1] = 8'h97; exp_flags[1] = 3'b010;
        exp_op[2] = 8'h2F; exp_flags[2] = 3'b101;
        issue(3'b001, 4'd3, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({o_op, o_sout, o_busy, o_done} !== {exp_op[k], exp_flags[k]}) begin
                bad++;
                $display("FAIL shl step%0d got=%h/%b/%b/%b exp=%h/%b", k + 1,
                         o_op, o_sout, o_busy, o_done, exp_op[k], exp_flags[k]);
            end
            if (k < 2) tick();
        end
        tick();
    endtask

    task automatic test_rotate();
        issue(3'b000, 4'd0, 8'h81, 1'b0);
        issue(3'b011, 4'd8, 8'h00, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            total++;
            if ({o_busy, o_done} !== {(k < 8), (k == 8)}) begin
                bad++;
                $display("FAIL ror8_hs cycle%0d got=%b%b exp=%b%b", k, o_busy, o_done,
                         (k < 8), (k == 8));
            end
            if (k < 8) tick();
        end
        total++;
        if ({o_op, o_sout} !== {8'h81, 1'b1}) begin
            bad++;
            $display("FAIL ror8_result got=%h/%b exp=81/1", o_op, o_sout);
        end
        tick();
        issue(3'b100, 4'd1, 8'h00, 1'b0);
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h03, 3'b101}) begin
            bad++;
            $display("FAIL rol1 got=%h/%b/%b/%b exp=03/1/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
    endtask

    task automatic test_asr_shr();
        issue(3'b000, 4'd0, 8'h90, 1'b0);
        issue(3'b101, 4'd2, 8'h00, 1'b1);
        tick();
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'hE4, 3'b001}) begin
            bad++;
            $display("FAIL asr2 got=%h/%b/%b/%b exp=e4/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
        issue(3'b000, 4'd0, 8'h90, 1'b0);
        issue(3'b010, 4'd4, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h09, 3'b001}) begin
            bad++;
            $display("FAIL shr4 got=%h/%b/%b/%b exp=09/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        issue(3'b000, 4'd0, 8'h0F, 1'b0);
        issue(3'b001, 4'd3, 8'h00, 1'b0);
        // Competing command while busy
        i_start = 1'b1;
        i_mode  = 3'b010;
        i_amt   = 4'd1;
        i_ip    = 8'hFF;
        tick();
        i_start = 1'b0;
        i_sin   = 1'b0;
        tick();
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h78, 3'b001}) begin
            bad++;
            $display("FAIL busy_ignore got=%h/%b/%b/%b exp=78/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
        total++;
        if ({o_op, o_busy, o_done} !== {8'h78, 2'b00}) begin
            bad++;
            $display("FAIL busy_no_redone got=%h/%b/%b exp=78/0/0", o_op, o_busy, o_done);
        end
    endtask

    task automatic test_noop();
        issue(3'b001, 4'd0, 8'hFF, 1'b1);
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h78, 3'b001}) begin
            bad++;
            $display("FAIL amt0 got=%h/%b/%b/%b exp=78/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
        issue(3'b111, 4'd5, 8'hFF, 1'b1);
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h78, 3'b001}) begin
            bad++;
            $display("FAIL reserved got=%h/%b/%b/%b exp=78/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
        total++;
        if ({o_busy, o_done} !== 2'b00) begin
            bad++;
            $display("FAIL reserved_after got=%b%b exp=00", o_busy, o_done);
        end
    endtask

    task automatic test_back_to_back();
        issue(3'b000, 4'd0, 8'h3C, 1'b0);
        // Start in the DONE cycle
        issue(3'b001, 4'd1, 8'h00, 1'b0);
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== {8'h78, 3'b001}) begin
            bad++;
            $display("FAIL back_to_back got=%h/%b/%b/%b exp=78/0/0/1", o_op, o_sout, o_busy, o_done);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        issue(3'b000, 4'd0, 8'h55, 1'b0);
        issue(3'b001, 4'd10, 8'h00, 1'b1);
        tick();
        tick();
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_busy got=%b exp=1", o_busy);
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++;
        if ({o_op, o_sout, o_busy, o_done} !== 11'b0) begin
            bad++;
            $display("FAIL rst_mid got=%h/%b/%b/%b exp=00/0/0/0", o_op, o_sout, o_busy, o_done);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if ({o_op, o_sout, o_busy, o_done} !== 11'b0) begin
                bad++;
                $display("FAIL rst_abandon cycle%0d got=%h/%b/%b/%b exp=00/0/0/0", k,
                         o_op, o_sout, o_busy, o_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_rotate();
        test_asr_shr();
        test_busy_ignore();
        test_noop();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
